fetch_arb_ctl: RTL and testbench
================================

# fetch_arb_ctl

Multi-channel successor to the single-FIFO fetch control in the NOU ingress path. It arbitrates among NUM_CH input FIFOs (round-robin), issues at most one FIFO read per cycle, and flow-controls against the downstream request queue (XRQ) with a credit counter instead of full/almost-full flags. It produces a registered valid plus channel tag aligned with FIFO read data in stage f1.

## Interface
- NUM_CH, 4: number of input FIFOs/channels, 1..16.
- XRQ_DEPTH, 16: XRQ entries; initial credit count, 2..255.
- CRD_RSV, 1: credits held in reserve; issue only while credit count > CRD_RSV (replaces almost-full), 0..XRQ_DEPTH-1.
- BURST_LEN, 4: max consecutive reads per grant when burst mode is compiled in, 1..16.
- clk  in  1  clock; all logic posedge.
- rstn  in  1  asynchronous active-low reset.
- fetch_en  in  1  level; 0 blocks new reads. Outstanding f1 beats still complete.
- fifo_empty_f0  in  NUM_CH  per-channel empty flag.
- fifo_rd_en_f0  out  NUM_CH  read strobe; one-hot or zero.
- xrq_crd_rtn  in  1  one credit returned per cycle high.
- data_vld_f1  out  1  FIFO read data valid. Registered, one cycle after rd_en.
- data_ch_f1  out  $clog2(NUM_CH) (min 1)  channel of the f1 beat.
- crd_cnt  out  $clog2(XRQ_DEPTH+1)  current credit count (debug/perf).
- err_crd_ovf  out  1  sticky; a credit was returned while crd_cnt == XRQ_DEPTH.

## Operation
- Request vector: req[i] = ~fifo_empty_f0[i]. Issue = fetch_en & |req & (crd_cnt > CRD_RSV).
- Round-robin: rr_ptr holds the last granted index. Grant the first requester scanning rr_ptr+1, rr_ptr+2, ... with wrap at NUM_CH. rr_ptr updates only on issue.
- fifo_rd_en_f0 = grant one-hot when Issue, else 0.
- Credit counter: issue only → -1; return only → +1; both or neither → unchanged. Return at XRQ_DEPTH with no issue → saturate at XRQ_DEPTH and set err_crd_ovf; it clears only on reset.
- The f1 register captures vld = Issue and ch = granted index. When vld = 0, data_ch_f1 holds its previous value.
- fetch_en deasserting mid-stream: no read in that cycle. A beat issued the previous cycle still appears on f1.

## Timing
- fifo_rd_en_f0: combinational from fifo_empty_f0, fetch_en and registered state (crd_cnt, rr_ptr, lock). Zero-cycle response to empty.
- data_vld_f1/data_ch_f1: exactly 1 cycle after the corresponding fifo_rd_en_f0. Throughput is 1 beat/cycle while credits last.
- Credit return takes effect on issue eligibility in the next cycle, not the same cycle.
- Reset values: fifo_rd_en_f0 = 0 (follows reset state), data_vld_f1 = 0, data_ch_f1 = 0, crd_cnt = XRQ_DEPTH, err_crd_ovf = 0, rr_ptr = NUM_CH-1 (channel 0 wins first), lock cleared.
- Reset mid-operation: all state returns to reset values immediately. In-flight credits are forgotten; the XRQ is reset in the same domain.

## Configuration
- NOU_FETCH_BURST_EN defined:
  - After a grant to channel k, lock onto k for up to BURST_LEN consecutive issues.
  - The lock holds through credit or fetch_en stalls (no issue, no re-arbitration).
  - The lock releases when the BURST_LEN-th beat issues, or in any cycle where req[k] = 0. In that cycle, arbitration proceeds normally among the other channels.
  - rr_ptr = k on release.
- NOU_FETCH_BURST_EN undefined: every issue re-arbitrates. BURST_LEN is ignored and no lock/beat-counter logic is present.

## Structure
- nou_fetch_pkg holds:
  - default parameter constants: NOU_FETCH_NUM_CH, NOU_XRQ_DEPTH, NOU_FETCH_CRD_RSV, NOU_FETCH_BURST_LEN;
  - typedef of the credit-count width.
- One sub-module, nou_rr_arb: parametrised NUM_CH round-robin arbiter with inputs req, ptr and a lock override; output one-hot grant plus encoded index.
- Credit counter, burst lock and f1 register stay in fetch_arb_ctl.

## Test plan
- Reset, then all 4 FIFOs nonempty, no credit returns, CRD_RSV = 1 → rd_en order ch0, ch1, ch2, ch3, ch0 … (burst off). Exactly 15 reads, then a stall with crd_cnt = 1. Each data_vld_f1 lags by 1 cycle with matching data_ch_f1.
- From crd_cnt = 1, pulse xrq_crd_rtn for 1 cycle → crd_cnt = 2 next cycle. One read issues the following cycle, then crd_cnt = 1 again.
- Issue and xrq_crd_rtn in the same cycle at crd_cnt = 8 → crd_cnt stays 8.
- After reset, one extra xrq_crd_rtn → crd_cnt stays 16 and err_crd_ovf = 1 until rstn low.
- NOU_FETCH_BURST_EN, BURST_LEN = 4, ch0 and ch2 nonempty → ch0 ×4, ch2 ×4, ch0 ×4. Make ch0 empty after 2 beats → ch2 is granted in the same cycle that ch0 empties.
- fetch_en dropped for 3 cycles mid-stream, then rstn pulsed during traffic → no rd_en while fetch_en = 0, and the pending f1 beat still completes. On reset, all outputs return to reset values and the next grant is ch0.

Source files
------------

// File: rtl/nou_fetch_pkg.sv
// Shared defaults and helpers for the NOU multi-channel fetch control.
package nou_fetch_pkg;

   localparam int unsigned NOU_FETCH_NUM_CH    = 4;
   localparam int unsigned NOU_XRQ_DEPTH       = 16;
   localparam int unsigned NOU_FETCH_CRD_RSV   = 1;
   localparam int unsigned NOU_FETCH_BURST_LEN = 4;

   localparam int unsigned NOU_CRD_W = $clog2(NOU_XRQ_DEPTH + 1);
   typedef logic [NOU_CRD_W-1:0] nou_crd_cnt_t;

   // Channel index width, never narrower than one bit.
   function automatic int unsigned nou_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nou_rr_arb.sv
// Round-robin arbiter: grants the first requester after ptr, or lock_idx when lock_en.
module nou_rr_arb
   import nou_fetch_pkg::*;
#(
   parameter int unsigned NUM_CH = NOU_FETCH_NUM_CH,
   parameter int unsigned IDX_W  = nou_idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   input  logic              lock_en,
   input  logic [IDX_W-1:0]  lock_idx,
   output logic [NUM_CH-1:0] gnt,
   output logic [IDX_W-1:0]  gnt_idx,
   output logic              gnt_vld
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      if (lock_en) begin
         gnt_idx = lock_idx;
         gnt_vld = 1'b1;
      end else begin
         for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NUM_CH);
            if (!gnt_vld && req[idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = idx;
            end
         end
      end
      gnt = gnt_vld ? (NUM_CH'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/fetch_arb_ctl.sv
// Multi-channel round-robin FIFO fetch control with XRQ credit flow control.
// Define NOU_FETCH_BURST_EN to lock each grant for up to BURST_LEN beats.
module fetch_arb_ctl
   import nou_fetch_pkg::*;
#(
   parameter int unsigned NUM_CH    = NOU_FETCH_NUM_CH,
   parameter int unsigned XRQ_DEPTH = NOU_XRQ_DEPTH,
   parameter int unsigned CRD_RSV   = NOU_FETCH_CRD_RSV,
   parameter int unsigned BURST_LEN = NOU_FETCH_BURST_LEN
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                fetch_en,
   input  logic [NUM_CH-1:0]                   fifo_empty_f0,
   output logic [NUM_CH-1:0]                   fifo_rd_en_f0,
   input  logic                                xrq_crd_rtn,
   output logic                                data_vld_f1,
   output logic [nou_idx_w(NUM_CH)-1:0]        data_ch_f1,
   output logic [$clog2(XRQ_DEPTH+1)-1:0]      crd_cnt,
   output logic                                err_crd_ovf
);

   localparam int unsigned IDX_W = nou_idx_w(NUM_CH);
   localparam int unsigned CRD_W = $clog2(XRQ_DEPTH + 1);
   localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(XRQ_DEPTH);
   localparam logic [CRD_W-1:0] CRD_RES = CRD_W'(CRD_RSV);

   if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("NUM_CH out of range");
   end
   if (XRQ_DEPTH < 2 || XRQ_DEPTH > 255 || CRD_RSV >= XRQ_DEPTH) begin : g_bad_crd
      $error("XRQ_DEPTH/CRD_RSV out of range");
   end
   if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst
      $error("BURST_LEN out of range");
   end

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic              gnt_vld;
   logic [IDX_W-1:0]  rr_ptr;
   logic              lock_act;
   logic [IDX_W-1:0]  lock_ch;
   logic              issue;

   assign req   = ~fifo_empty_f0;
   assign issue = fetch_en & gnt_vld & (crd_cnt > CRD_RES);
   assign fifo_rd_en_f0 = issue ? gnt : '0;

   nou_rr_arb #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_arb (
      .req      (req),
      .ptr      (rr_ptr),
      .lock_en  (lock_act),
      .lock_idx (lock_ch),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .gnt_vld  (gnt_vld)
   );

`ifdef NOU_FETCH_BURST_EN
   localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
   typedef enum logic { LK_IDLE, LK_HELD } lock_e;

   lock_e             lock_st;
   logic [BEAT_W-1:0] beat_cnt;

   // A held lock whose channel has drained drops out here, so the arbiter
   // falls back to a normal scan in that same cycle.
   assign lock_act = (lock_st == LK_HELD) & req[lock_ch];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lock_st  <= LK_IDLE;
         lock_ch  <= '0;
         beat_cnt <= '0;
      end else if (issue) begin
         if (lock_act) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BEAT_W'(BURST_LEN - 1)) lock_st <= LK_IDLE;
         end else begin
            lock_ch  <= gnt_idx;
            beat_cnt <= BEAT_W'(1);
            lock_st  <= (BURST_LEN > 1) ? LK_HELD : LK_IDLE;
         end
      end else if (lock_st == LK_HELD && !req[lock_ch]) begin
         lock_st <= LK_IDLE;
      end
   end
`else
   assign lock_act = 1'b0;
   assign lock_ch  = '0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr      <= IDX_W'(NUM_CH - 1);
         crd_cnt     <= CRD_MAX;
         err_crd_ovf <= 1'b0;
         data_vld_f1 <= 1'b0;
         data_ch_f1  <= '0;
      end else begin
         data_vld_f1 <= issue;
         if (issue) begin
            rr_ptr     <= gnt_idx;
            data_ch_f1 <= gnt_idx;
         end
         case ({issue, xrq_crd_rtn})
            2'b10:   crd_cnt <= crd_cnt - 1'b1;
            2'b01: begin
               if (crd_cnt == CRD_MAX) err_crd_ovf <= 1'b1;
               else                    crd_cnt     <= crd_cnt + 1'b1;
            end
            default: crd_cnt <= crd_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_arb_ctl.sv
// Self-checking bench for fetch_arb_ctl: spec-level model plus directed literal checks.
module tb_fetch_arb_ctl;

   localparam int NCH   = 4;
   localparam int DEPTH = 16;
   localparam int RSV   = 1;
   localparam int BL    = 4;
`ifdef NOU_FETCH_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn;
   logic       fetch_en;
   logic [3:0] fifo_empty_f0;
   logic [3:0] fifo_rd_en_f0;
   logic       xrq_crd_rtn;
   logic       data_vld_f1;
   logic [1:0] data_ch_f1;
   logic [4:0] crd_cnt;
   logic       err_crd_ovf;

   int errors = 0;
   int checks = 0;
   int log_q[$];

   fetch_arb_ctl #(
      .NUM_CH    (NCH),
      .XRQ_DEPTH (DEPTH),
      .CRD_RSV   (RSV),
      .BURST_LEN (BL)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .fetch_en      (fetch_en),
      .fifo_empty_f0 (fifo_empty_f0),
      .fifo_rd_en_f0 (fifo_rd_en_f0),
      .xrq_crd_rtn   (xrq_crd_rtn),
      .data_vld_f1   (data_vld_f1),
      .data_ch_f1    (data_ch_f1),
      .crd_cnt       (crd_cnt),
      .err_crd_ovf   (err_crd_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model state: what the spec says the block holds after each edge.
   int m_crd, m_rr, m_ch, m_lk, m_beats;
   bit m_ovf, m_vld, m_lock;
   int g;
   bit elig, la;
   int exp_rd;

   always @(negedge clk) begin
      if (!rstn) begin
         m_crd = DEPTH; m_rr = NCH - 1; m_ch = 0; m_ovf = 0; m_vld = 0;
         m_lock = 0; m_lk = 0; m_beats = 0;
         chk("rst_vld", int'(data_vld_f1), 0);
         chk("rst_ch",  int'(data_ch_f1),  0);
         chk("rst_crd", int'(crd_cnt),     DEPTH);
         chk("rst_ovf", int'(err_crd_ovf), 0);
         if (!fetch_en) chk("rst_rd", int'(fifo_rd_en_f0), 0);
      end else begin
         la = BURST && m_lock && !fifo_empty_f0[m_lk];
         g = -1;
         if (la) g = m_lk;
         else
            for (int i = 1; i <= NCH; i++) begin
               int c;
               c = (m_rr + i) % NCH;
               if (g < 0 && !fifo_empty_f0[c]) g = c;
            end
         elig   = fetch_en && (g >= 0) && (m_crd > RSV);
         exp_rd = elig ? (1 << g) : 0;
         chk("rd_en", int'(fifo_rd_en_f0), exp_rd);
         chk("vld",   int'(data_vld_f1),   int'(m_vld));
         if (m_vld) chk("ch", int'(data_ch_f1), m_ch);
         chk("crd",   int'(crd_cnt),       m_crd);
         chk("ovf",   int'(err_crd_ovf),   int'(m_ovf));
         // advance to the state after the coming posedge
         m_vld = elig;
         if (elig) begin
            m_ch = g; m_rr = g;
            log_q.push_back(g);
         end
         if (elig && !xrq_crd_rtn) m_crd--;
         else if (!elig && xrq_crd_rtn) begin
            if (m_crd == DEPTH) m_ovf = 1;
            else m_crd++;
         end
         if (BURST) begin
            if (elig) begin
               if (la) begin
                  m_beats++;
                  if (m_beats == BL) m_lock = 0;
               end else begin
                  m_lock = (BL > 1); m_lk = g; m_beats = 1;
               end
            end else if (m_lock && fifo_empty_f0[m_lk]) m_lock = 0;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic look();
      @(negedge clk); #1;
   endtask

   initial begin
      rstn = 0; fetch_en = 0; fifo_empty_f0 = 4'hF; xrq_crd_rtn = 0;
      cyc(2); look();
      chk("lit_rst_crd", int'(crd_cnt), 16);
      chk("lit_rst_vld", int'(data_vld_f1), 0);
      chk("lit_rst_rd",  int'(fifo_rd_en_f0), 0);

      // All channels busy, no returns: 15 reads then stall at crd 1
      cyc(1); rstn = 1;
      cyc(1); log_q.delete(); fetch_en = 1; fifo_empty_f0 = 4'h0;
      cyc(20); look();
      chk("lit_nreads", log_q.size(), 15);
      chk("lit_stall_crd", int'(crd_cnt), 1);
      chk("lit_stall_rd", int'(fifo_rd_en_f0), 0);
      for (int i = 0; i < 15 && i < log_q.size(); i++)
         chk("lit_order", log_q[i], BURST ? (i / 4) % 4 : i % 4);

      // One credit back: visible next cycle, one read, back to 1
      cyc(1); xrq_crd_rtn = 1;
      cyc(1); xrq_crd_rtn = 0; look();
      chk("lit_rtn_crd", int'(crd_cnt), 2);
      chk("lit_rtn_rd", int'(fifo_rd_en_f0), 4'b1000);
      cyc(1); look();
      chk("lit_rtn_crd2", int'(crd_cnt), 1);
      chk("lit_rtn_rd2", int'(fifo_rd_en_f0), 0);

      // Issue and return together at crd 8
      cyc(1); rstn = 0; fetch_en = 0;
      cyc(1); rstn = 1;
      cyc(1); fetch_en = 1;
      cyc(8); fetch_en = 0; look();
      chk("lit_crd8", int'(crd_cnt), 8);
      cyc(1); fetch_en = 1; xrq_crd_rtn = 1; look();
      chk("lit_both_rd", int'(fifo_rd_en_f0 != 0), 1);
      cyc(1); fetch_en = 0; xrq_crd_rtn = 0; look();
      chk("lit_both_crd", int'(crd_cnt), 8);

      // Overflow is sticky until reset
      cyc(1); rstn = 0;
      cyc(1); rstn = 1;
      cyc(1); xrq_crd_rtn = 1;
      cyc(1); xrq_crd_rtn = 0; look();
      chk("lit_ovf_crd", int'(crd_cnt), 16);
      chk("lit_ovf", int'(err_crd_ovf), 1);
      cyc(3); look();
      chk("lit_ovf_sticky", int'(err_crd_ovf), 1);
      cyc(1); rstn = 0; look();
      chk("lit_ovf_clr", int'(err_crd_ovf), 0);
      cyc(1); rstn = 1;

      // fetch_en gap mid-stream, then reset during traffic
      cyc(1); fetch_en = 1;
      cyc(5); fetch_en = 0; look();
      chk("lit_gap_rd", int'(fifo_rd_en_f0), 0);
      chk("lit_gap_vld", int'(data_vld_f1), 1);
      cyc(1); look();
      chk("lit_gap_vld2", int'(data_vld_f1), 0);
      cyc(2); fetch_en = 1;
      cyc(2); rstn = 0; fetch_en = 0; look();
      chk("lit_mid_rst_vld", int'(data_vld_f1), 0);
      chk("lit_mid_rst_crd", int'(crd_cnt), 16);
      cyc(1); rstn = 1; fetch_en = 1; look();
      chk("lit_post_rst_rd", int'(fifo_rd_en_f0), 4'b0001);
      cyc(1); look();
      chk("lit_post_rst_vld", int'(data_vld_f1), 1);
      chk("lit_post_rst_ch", int'(data_ch_f1), 0);

`ifdef NOU_FETCH_BURST_EN
      begin
         int exp_b[12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
         cyc(1); fetch_en = 0; rstn = 0;
         cyc(1); rstn = 1; fifo_empty_f0 = 4'b1010; log_q.delete();
         fetch_en = 1; xrq_crd_rtn = 1;
         cyc(12); fetch_en = 0; xrq_crd_rtn = 0;
         chk("lit_burst_n", log_q.size(), 12);
         for (int i = 0; i < 12 && i < log_q.size(); i++)
            chk("lit_burst_order", log_q[i], exp_b[i]);
         cyc(1); rstn = 0;
         cyc(1); rstn = 1; fifo_empty_f0 = 4'b1010; log_q.delete(); fetch_en = 1;
         cyc(2); fifo_empty_f0 = 4'b1011; look();
         chk("lit_burst_drain_rd", int'(fifo_rd_en_f0), 4'b0100);
         cyc(3); fetch_en = 0;
         chk("lit_burst_drain_n", int'(log_q.size() >= 3), 1);
         if (log_q.size() >= 3) chk("lit_burst_drain_3rd", log_q[2], 2);
      end
`endif

      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
